// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers, also used by the frame-buffer reader and drawer.
package vga_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned FC_W  = 8;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned act, input int unsigned fp);
    return act + fp;
  endfunction

  function automatic int unsigned sync_last(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync);
    return act + fp + sync - 1;
  endfunction

  localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Restart marks the first cycle after reset, when the origin is re-entered.
  typedef enum logic {
    ST_RESTART = 1'b0,
    ST_RUN     = 1'b1
  } frame_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus terminal, sync-window and active flags
// evaluated on the next-state count so the caller can register them aligned with the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL_DEF,
  parameter int unsigned ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned SYNC_FIRST = sync_first(H_ACTIVE_DEF, H_FP_DEF),
  parameter int unsigned SYNC_LAST  = sync_last(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic             terminal_c,
  output logic             sync_win_c,
  output logic             active_c
);

  logic [CNT_W-1:0] count_next_c;

  // >= so an out-of-range value can never persist past one enabled edge
  assign terminal_c = (count >= CNT_W'(TOTAL - 1));

  always_comb begin
    count_next_c = count;
    if (count_en) begin
      count_next_c = terminal_c ? '0 : count + CNT_W'(1);
    end
  end

  assign sync_win_c = (count_next_c >= CNT_W'(SYNC_FIRST)) && (count_next_c <= CNT_W'(SYNC_LAST));
  assign active_c   = (count_next_c < CNT_W'(ACTIVE));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: half-rate pixel enable, column/row counters, registered syncs,
// video-on/blank, frame-start pulse and completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             PixelEn,
  output logic [CNT_W-1:0] Columna,
  output logic [CNT_W-1:0] Fila,
  output logic             Hsync,
  output logic             Vsync,
  output logic             VideoOn,
  output logic             VGA_blank,
  output logic             FrameStart,
  output logic [FC_W-1:0]  FrameCount
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  frame_state_t state_q;
  frame_state_t state_d;

  logic h_term_c, h_sync_win_c, h_active_c;
  logic v_term_c, v_sync_win_c, v_active_c;
  logic line_end_c, frame_end_c, frame_start_d;

  assign line_end_c  = PixelEn & h_term_c;
  assign frame_end_c = line_end_c & v_term_c;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_FIRST (sync_first(H_ACTIVE, H_FP)),
    .SYNC_LAST  (sync_last(H_ACTIVE, H_FP, H_SYNC))
  ) u_h_axis (
    .Clk        (Clk),
    .Reset      (Reset),
    .count_en   (PixelEn),
    .count      (Columna),
    .terminal_c (h_term_c),
    .sync_win_c (h_sync_win_c),
    .active_c   (h_active_c)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_FIRST (sync_first(V_ACTIVE, V_FP)),
    .SYNC_LAST  (sync_last(V_ACTIVE, V_FP, V_SYNC))
  ) u_v_axis (
    .Clk        (Clk),
    .Reset      (Reset),
    .count_en   (line_end_c),
    .count      (Fila),
    .terminal_c (v_term_c),
    .sync_win_c (v_sync_win_c),
    .active_c   (v_active_c)
  );

  // Frame start fires on a natural wrap or when leaving reset.
  always_comb begin
    state_d       = ST_RUN;
    frame_start_d = frame_end_c;
    case (state_q)
      ST_RESTART: frame_start_d = 1'b1;
      ST_RUN:     frame_start_d = frame_end_c;
      default:    state_d       = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RESTART;
    end else begin
      state_q <= state_d;
    end
  end

  // Flags come from next-state counts, so they line up with Columna/Fila.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PixelEn    <= 1'b0;
      Hsync      <= 1'b1;
      Vsync      <= 1'b1;
      VideoOn    <= 1'b1;
      VGA_blank  <= 1'b1;
      FrameStart <= 1'b0;
      FrameCount <= '0;
    end else begin
      PixelEn    <= ~PixelEn;
      Hsync      <= ~h_sync_win_c;
      Vsync      <= ~v_sync_win_c;
      VideoOn    <= h_active_c & v_active_c;
      VGA_blank  <= h_active_c & v_active_c;
      FrameStart <= frame_start_d;
      if (frame_end_c) begin
        FrameCount <= FrameCount + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (8x6) so 256 frames stay short.
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FP = HT * VT;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PixelEn;
  logic [10:0] Columna;
  logic [10:0] Fila;
  logic        Hsync, Vsync, VideoOn, VGA_blank, FrameStart;
  logic [7:0]  FrameCount;

  int total = 0;
  int bad = 0;
  int k = -2;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .Clk(Clk), .Reset(Reset), .PixelEn(PixelEn), .Columna(Columna), .Fila(Fila),
    .Hsync(Hsync), .Vsync(Vsync), .VideoOn(VideoOn), .VGA_blank(VGA_blank),
    .FrameStart(FrameStart), .FrameCount(FrameCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d k=%0d t=%0t", name, act, exp, k, $time);
    end
  endtask

  // Cycles since reset release; -1 means the last edge applied reset.
  always @(posedge Clk) begin
    if (Reset) k <= -1;
    else if (k >= -1) k <= k + 1;
  end

  // Raster model: k-th post-reset cycle shows pixel (k+1)/2 of an endless scan.
  always @(negedge Clk) begin : cmp
    int n, p, col, row, fs;
    if (k == -1) begin
      chk("rst_pe", int'(PixelEn), 0);
      chk("rst_col", int'(Columna), 0);
      chk("rst_row", int'(Fila), 0);
      chk("rst_hs", int'(Hsync), 1);
      chk("rst_vs", int'(Vsync), 1);
      chk("rst_von", int'(VideoOn), 1);
      chk("rst_blank", int'(VGA_blank), 1);
      chk("rst_fs", int'(FrameStart), 0);
      chk("rst_fc", int'(FrameCount), 0);
    end else if (k >= 0) begin
      n   = (k + 1) / 2;
      p   = n % FP;
      col = p % HT;
      row = p / HT;
      fs  = (p == 0 && (k == 0 || (k % 2) == 1)) ? 1 : 0;
      chk("pe", int'(PixelEn), (k % 2 == 0) ? 1 : 0);
      chk("col", int'(Columna), col);
      chk("row", int'(Fila), row);
      chk("hs", int'(Hsync), (col >= HA + HF && col < HA + HF + HS) ? 0 : 1);
      chk("vs", int'(Vsync), (row >= VA + VF && row < VA + VF + VS) ? 0 : 1);
      chk("von", int'(VideoOn), (col < HA && row < VA) ? 1 : 0);
      chk("blank", int'(VGA_blank), (col < HA && row < VA) ? 1 : 0);
      chk("fs", int'(FrameStart), fs);
      chk("fc", int'(FrameCount), (n / FP) % 256);
    end
  end

  initial begin : main
    int fs_k[$];
    int row1_k, row2_k, hs_low_row1, hs_first_col, vs_low, vid_row3, fs_in_win;
    int vid_c3, vid_c4, blank_c4, nb, seen_zero, hit;
    row1_k = -1; row2_k = -1; hs_low_row1 = 0; hs_first_col = -1;
    vs_low = 0; vid_row3 = 0; fs_in_win = 0; vid_c3 = -1; vid_c4 = -1; blank_c4 = -1;

    repeat (5) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_pe", int'(PixelEn), 1);
    chk("post_rst_fs", int'(FrameStart), 1);
    chk("post_rst_col", int'(Columna), 0);
    chk("post_rst_row", int'(Fila), 0);

    // Collect line/frame measurements over the second frame.
    for (int c = 1; c <= 4 * FP + 2; c++) begin
      @(negedge Clk);
      if (FrameStart) fs_k.push_back(c);
      if (fs_k.size() == 1) begin
        if (!Vsync) vs_low++;
        if (FrameStart) fs_in_win++;
        if (int'(Fila) == VA && VideoOn) vid_row3++;
        if (int'(Fila) == 1 && !Hsync) begin
          if (hs_low_row1 == 0) hs_first_col = int'(Columna);
          hs_low_row1++;
        end
        if (int'(Fila) == 1 && row1_k < 0) row1_k = c;
        if (int'(Fila) == 2 && row2_k < 0) row2_k = c;
        if (int'(Fila) == 2 && int'(Columna) == 3 && PixelEn) vid_c3 = int'(VideoOn);
        if (int'(Fila) == 2 && int'(Columna) == 4 && vid_c4 < 0) begin
          vid_c4 = int'(VideoOn);
          blank_c4 = int'(VGA_blank);
        end
      end
    end
    chk("fs_pulses", fs_k.size(), 2);
    if (fs_k.size() == 2) chk("frame_period", fs_k[1] - fs_k[0], 96);
    chk("fs_once", fs_in_win, 1);
    chk("vs_low_cycles", vs_low, 16);
    chk("hs_low_cycles", hs_low_row1, 4);
    chk("hs_first_col", hs_first_col, 5);
    chk("line_period", row2_k - row1_k, 16);
    chk("von_col3", vid_c3, 1);
    chk("von_col4", vid_c4, 0);
    chk("blank_col4", blank_c4, 0);
    chk("von_row3", vid_row3, 0);

    // FrameCount must wrap to zero on the 256th boundary.
    nb = fs_k.size();
    seen_zero = 0;
    for (int c = 0; c < 260 * 2 * FP; c++) begin
      @(negedge Clk);
      if (FrameStart) begin
        nb++;
        if (FrameCount == 8'd0) begin
          seen_zero = 1;
          break;
        end
      end
    end
    chk("fc_wrap_seen", seen_zero, 1);
    chk("fc_wrap_boundary", nb, 256);

    // Reset inside both sync pulses.
    hit = 0;
    for (int c = 0; c < 4 * FP; c++) begin
      @(negedge Clk);
      if (int'(Columna) == 6 && int'(Fila) == 4) begin
        hit = 1;
        break;
      end
    end
    chk("mid_hit", hit, 1);
    chk("mid_hs_low", int'(Hsync), 0);
    chk("mid_vs_low", int'(Vsync), 0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_hs", int'(Hsync), 1);
    chk("mid_rst_vs", int'(Vsync), 1);
    chk("mid_rst_col", int'(Columna), 0);
    chk("mid_rst_row", int'(Fila), 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid_post_pe", int'(PixelEn), 1);
    chk("mid_post_fs", int'(FrameStart), 1);
    repeat (3 * 2 * FP) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
